// File: rtl/frame_aligner_gen.sv
// Byte-stream frame aligner: hunts for a two-byte A/B header, tracks byte position, declares lock
// after LOCK_CNT good frames and flywheels over isolated bad headers while locked.
module frame_aligner_gen #(
   parameter int unsigned       DATA_W     = 8,
   parameter int unsigned       FRAME_LEN  = 12,
   parameter int unsigned       LOCK_CNT   = 3,
   parameter int unsigned       MISS_LIMIT = 2,
   parameter logic [DATA_W-1:0] HDR_A_LSB  = 8'hAA,
   parameter logic [DATA_W-1:0] HDR_A_MSB  = 8'hAF,
   parameter logic [DATA_W-1:0] HDR_B_LSB  = 8'h55,
   parameter logic [DATA_W-1:0] HDR_B_MSB  = 8'hBA,
   parameter int unsigned       ERR_W      = 8,
   localparam int unsigned      POS_W      = $clog2(FRAME_LEN)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rx_valid,
   input  logic [DATA_W-1:0] rx_data,
   output logic [POS_W-1:0]  fr_byte_position,
   output logic              frame_detect,
   output logic              frame_start,
   output logic              payload_valid,
   output logic              hdr_type,
   output logic [ERR_W-1:0]  frame_err_cnt
);

   localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);

   localparam logic [GOOD_W-1:0] LockMax   = GOOD_W'(LOCK_CNT);
   localparam logic [MISS_W-1:0] MissMax   = MISS_W'(MISS_LIMIT);
   localparam logic [POS_W-1:0]  PosPenult = POS_W'(FRAME_LEN - 2);
   localparam logic [POS_W-1:0]  PosOne    = POS_W'(1);

   typedef enum logic [2:0] {
      StHunt,
      StHdrMsb,
      StData,
      StFlyLsb,
      StFlyMsb
   } state_e;

   state_e            state;
   logic              cand_type;
   logic              fly_ok;
   logic              fly_type;
   logic [GOOD_W-1:0] good_cnt;
   logic [MISS_W-1:0] miss_cnt;

   logic              is_lsb_a;
   logic              is_lsb_b;
   logic              is_lsb;
   logic              lsb_type;
   logic              cand_msb_hit;
   logic              fly_msb_hit;
   logic [GOOD_W-1:0] good_inc;
   logic [MISS_W-1:0] miss_inc;

   assign is_lsb_a     = (rx_data == HDR_A_LSB);
   assign is_lsb_b     = (rx_data == HDR_B_LSB);
   assign is_lsb       = is_lsb_a | is_lsb_b;
   // Type A wins if both LSB patterns are programmed identically.
   assign lsb_type     = is_lsb_b & ~is_lsb_a;
   assign cand_msb_hit = (rx_data == (cand_type ? HDR_B_MSB : HDR_A_MSB));
   assign fly_msb_hit  = fly_ok & (rx_data == (fly_type ? HDR_B_MSB : HDR_A_MSB));
   assign good_inc     = (good_cnt == LockMax) ? good_cnt : good_cnt + 1'b1;
   assign miss_inc     = miss_cnt + 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= StHunt;
         cand_type        <= 1'b0;
         fly_ok           <= 1'b0;
         fly_type         <= 1'b0;
         good_cnt         <= '0;
         miss_cnt         <= '0;
         fr_byte_position <= '0;
         frame_detect     <= 1'b0;
         frame_start      <= 1'b0;
         payload_valid    <= 1'b0;
         hdr_type         <= 1'b0;
         frame_err_cnt    <= '0;
      end else begin
         frame_start   <= 1'b0;
         payload_valid <= 1'b0;
         if (rx_valid) begin
            unique case (state)
               StHunt: begin
                  fr_byte_position <= '0;
                  if (is_lsb) begin
                     state     <= StHdrMsb;
                     cand_type <= lsb_type;
                  end else begin
                     good_cnt <= '0;
                  end
               end
               StHdrMsb: begin
                  if (cand_msb_hit) begin
                     state            <= StData;
                     fr_byte_position <= PosOne;
                     frame_start      <= 1'b1;
                     hdr_type         <= cand_type;
                     good_cnt         <= good_inc;
                     if (good_inc == LockMax) frame_detect <= 1'b1;
                  end else if (is_lsb) begin
                     cand_type        <= lsb_type;
                     fr_byte_position <= '0;
                  end else begin
                     state            <= StHunt;
                     good_cnt         <= '0;
                     fr_byte_position <= '0;
                  end
               end
               StData: begin
                  fr_byte_position <= fr_byte_position + 1'b1;
                  payload_valid    <= 1'b1;
                  // good_cnt is kept on the unlocked exit so back-to-back frames accumulate.
                  if (fr_byte_position == PosPenult) begin
                     state <= frame_detect ? StFlyLsb : StHunt;
                  end
               end
               StFlyLsb: begin
                  fr_byte_position <= '0;
                  fly_ok           <= is_lsb;
                  fly_type         <= lsb_type;
                  state            <= StFlyMsb;
               end
               StFlyMsb: begin
                  fr_byte_position <= PosOne;
                  if (fly_msb_hit) begin
                     miss_cnt    <= '0;
                     frame_start <= 1'b1;
                     hdr_type    <= fly_type;
                     state       <= StData;
                  end else begin
                     if (frame_err_cnt != '1) frame_err_cnt <= frame_err_cnt + 1'b1;
                     if (miss_inc == MissMax) begin
                        frame_detect <= 1'b0;
                        good_cnt     <= '0;
                        miss_cnt     <= '0;
                        state        <= StHunt;
                     end else begin
                        // Flywheel: treat the frame as if its header were good, minus the strobe.
                        miss_cnt <= miss_inc;
                        state    <= StData;
                     end
                  end
               end
               default: state <= StHunt;
            endcase
         end
      end
   end

endmodule

// File: doc/frame_aligner_gen.md
Name: frame_aligner_gen

Overview:
Parametrised next-generation frame aligner for the byte-stream receive path. It hunts for a two-byte header with one of two programmable patterns and tracks byte position within fixed-length frames. It declares lock after LOCK_CNT consecutive good frames. Unlike the previous aligner it adds a per-byte valid qualifier, flywheel tolerance of isolated bad headers while locked, frame/payload strobes, header-type reporting and a saturating header-error counter.

Parameters:
DATA_W, 8, width of rx_data and header patterns
FRAME_LEN, 12, total bytes per frame including the 2 header bytes (>= 4)
LOCK_CNT, 3, consecutive confirmed headers needed to assert frame_detect (>= 1)
MISS_LIMIT, 2, consecutive bad headers while locked that drop lock (>= 1)
HDR_A_LSB, 8'hAA, first header byte, type A
HDR_A_MSB, 8'hAF, second header byte, type A
HDR_B_LSB, 8'h55, first header byte, type B
HDR_B_MSB, 8'hBA, second header byte, type B
ERR_W, 8, width of frame_err_cnt

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
rx_valid  input  1  rx_data qualifier; the block advances only on cycles with rx_valid=1
rx_data  input  DATA_W  received byte
fr_byte_position  output  POS_W=$clog2(FRAME_LEN)  position of last accepted byte in frame (0 = header LSB)
frame_detect  output  1  lock indication
frame_start  output  1  one-cycle pulse: header confirmed (on the accepted header MSB byte)
payload_valid  output  1  one-cycle pulse per accepted payload byte (positions 2..FRAME_LEN-1)
hdr_type  output  1  0 = type A, 1 = type B; last confirmed header type
frame_err_cnt  output  ERR_W  saturating count of bad headers seen while locked

Behaviour:
- All outputs registered. Reset (asynchronous, reset_n=0) forces state HUNT, all outputs 0, internal good_cnt=0, miss_cnt=0. Reset mid-frame abandons the frame; hunting restarts from the first accepted byte after release.
- Accepted byte = rx_valid=1 at a clk edge. When rx_valid=0: no state, counter or output change, except frame_start and payload_valid, which are 0.
- Outputs for an accepted byte appear on the same clk edge that accepts it (1-cycle latency from input to visible output).
- States:
  HUNT: a byte equal to HDR_A_LSB or HDR_B_LSB moves to HDR_MSB and latches the candidate type; pos=0. Any other byte stays in HUNT, sets good_cnt=0 and pos=0.
  HDR_MSB: a byte matching the MSB for the latched type moves to DATA, sets pos=1, pulses frame_start, updates hdr_type and increments good_cnt (saturating at LOCK_CNT). If good_cnt thereby reaches LOCK_CNT, frame_detect=1 on this same edge. If the byte is itself a valid LSB pattern, stay in HDR_MSB with the new candidate type, pos=0 (resync on repeated LSB). Otherwise go to HUNT with good_cnt=0.
  DATA: each accepted byte increments pos and pulses payload_valid. The byte at pos FRAME_LEN-1 leaves DATA: to FLY_LSB if frame_detect=1, else to HUNT (good_cnt kept, so back-to-back frames accumulate).
  FLY_LSB: the byte is taken as header LSB unconditionally; pos=0; match flag and type are recorded. Go to FLY_MSB.
  FLY_MSB: pos=1.
  - Good header (LSB valid and MSB matches its type): miss_cnt=0, frame_start pulse, hdr_type updated, go to DATA.
  - Bad header (either byte wrong): frame_err_cnt++ (saturates at all-ones) and miss_cnt++.
    - If miss_cnt reaches MISS_LIMIT: frame_detect=0, good_cnt=0, miss_cnt=0, go to HUNT. This byte is discarded, not re-examined.
    - Otherwise go to DATA (flywheel): pos continues, payload_valid pulses, frame_start stays 0.
- Lock is never lost outside FLY_MSB. frame_err_cnt is cleared only by reset.
- pos arithmetic is POS_W bits and never exceeds FRAME_LEN-1.

Test Plan:
1. Defaults; bytes AA AF + 10 payload, repeated 3 times back-to-back -> frame_start pulses 3 times; frame_detect rises on the edge accepting the 3rd AF; payload_valid pulses 10 per frame; hdr_type=0.
2. Lock on 55 BA frames; corrupt one header to 55 00 -> frame_err_cnt=1, frame_detect stays 1, that frame's 10 payload bytes still pulse payload_valid, no frame_start. A following good header clears miss_cnt.
3. Locked; two consecutive headers corrupted (00 00) -> frame_detect falls on the edge accepting the 2nd bad MSB; frame_err_cnt=2. The next AA AF starts a new hunt, and frame_detect needs 3 more good frames.
4. Stream AA AA AF + payload -> header confirmed at the 3rd byte, pos=1 there. Stream 55 AF -> no frame_start; FSM returns to HUNT.
5. Random rx_valid=0 gaps inserted inside the frames of scenario 1 -> same pos sequence and lock point, as counted in accepted bytes; no pulses on invalid cycles.
6. reset_n asserted while locked in mid-DATA -> all outputs 0 immediately, without waiting for a clk edge. After release, 3 fresh frames are required to relock. frame_err_cnt forced to saturate at 255 with repeated bad headers.
